slip_cmd_frame_buf: RTL and testbench

Command-frame assembler between the SLIP receive decoder and the EEPROM command sequencer. It captures the decoded SLIP byte events into a fixed-length frame, checks length and opcode, and presents one accepted command (opcode, page address, 8 data bytes) on a valid/ready interface. Malformed, truncated, oversized or colliding frames are dropped, flagged and counted, so the sequencer only ever sees well-formed commands.

---
 rtl/slip_cmd_frame_buf.sv | 201 ++++++++++++++++++++
 tb/tb_slip_cmd_frame_buf.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/slip_cmd_frame_buf.sv
// Assembles decoded SLIP byte events into one fixed-length command frame and
// hands it to the sequencer on valid/ready. Optional XOR checksum: SLIP_CMD_XOR_CHECK_EN.
module slip_cmd_frame_buf #(
    parameter int unsigned DATA_BYTES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_rx_started,
    input  logic                    i_rx_ended,
    input  logic                    i_rx_byte_done,
    input  logic [7:0]              i_rx_byte,
    output logic                    o_frame_valid,
    input  logic                    i_frame_ready,
    output logic [7:0]              o_cmd,
    output logic [7:0]              o_page_addr,
    output logic [8*DATA_BYTES-1:0] o_data,
    output logic                    o_busy,
    output logic                    o_len_err,
    output logic                    o_cmd_err,
    output logic                    o_sum_err,
    output logic [7:0]              o_drop_cnt
);

    localparam int unsigned FRAME_LEN = DATA_BYTES + 2;
`ifdef SLIP_CMD_XOR_CHECK_EN
    localparam int unsigned EXP_LEN = FRAME_LEN + 1;
`else
    localparam int unsigned EXP_LEN = FRAME_LEN;
`endif
    localparam int unsigned IDX_W = $clog2(EXP_LEN + 2);
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_CHECK   = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             started_q, ended_q, byte_done_q;
    logic [7:0]       byte_q;
    logic             wr_en, drop_inc, sum_bad;
    logic             frame_valid_d, busy_d, len_err_d, cmd_err_d, sum_err_d;

    // Input event register: keeps every output free of input-to-output paths.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started_q   <= 1'b0;
            ended_q     <= 1'b0;
            byte_done_q <= 1'b0;
            byte_q      <= 8'h00;
        end else begin
            started_q   <= i_rx_started;
            ended_q     <= i_rx_ended;
            byte_done_q <= i_rx_byte_done;
            byte_q      <= i_rx_byte;
        end
    end

`ifdef SLIP_CMD_XOR_CHECK_EN
    // Running XOR over every stored byte; zero when the trailing checksum matches.
    logic [7:0] chk_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chk_q <= 8'h00;
        end else if (idx_d == IDX_W'(0) && idx_q != IDX_W'(0)) begin
            chk_q <= 8'h00;
        end else if (state_d == S_COLLECT && state_q != S_COLLECT) begin
            chk_q <= 8'h00;
        end else if (wr_en) begin
            chk_q <= chk_q ^ byte_q;
        end
    end
    assign sum_bad = (chk_q != 8'h00);
`else
    assign sum_bad = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_en         = 1'b0;
        drop_inc      = 1'b0;
        frame_valid_d = 1'b0;
        len_err_d     = 1'b0;
        cmd_err_d     = 1'b0;
        sum_err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (started_q) begin
                    state_d = S_COLLECT;
                    idx_d   = '0;
                end
            end
            S_COLLECT: begin
                if (started_q) begin
                    // Start without end: abandon the partial frame, collect the new one.
                    drop_inc  = 1'b1;
                    len_err_d = 1'b1;
                    idx_d     = '0;
                end else begin
                    if (byte_done_q) begin
                        wr_en = (idx_q < IDX_W'(EXP_LEN));
                        if (idx_q != IDX_W'(EXP_LEN + 1)) begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                    if (ended_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (idx_q != IDX_W'(EXP_LEN)) begin
                    len_err_d = 1'b1;
                end else if (o_cmd != CMD_READ && o_cmd != CMD_WRITE) begin
                    cmd_err_d = 1'b1;
                end else if (sum_bad) begin
                    sum_err_d = 1'b1;
                end
                if (len_err_d || cmd_err_d || sum_err_d) begin
                    drop_inc = 1'b1;
                    if (started_q) begin
                        state_d = S_COLLECT;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d       = S_HOLD;
                    frame_valid_d = 1'b1;
                    drop_inc      = started_q;
                end
            end
            default: begin
                frame_valid_d = 1'b1;
                drop_inc      = started_q;
                if (o_frame_valid && i_frame_ready) begin
                    state_d       = S_IDLE;
                    frame_valid_d = 1'b0;
                end
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, index and captured frame bytes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q         <= '0;
            o_frame_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_len_err     <= 1'b0;
            o_cmd_err     <= 1'b0;
            o_drop_cnt    <= 8'h00;
            o_cmd         <= 8'h00;
            o_page_addr   <= 8'h00;
            o_data        <= '0;
        end else begin
            idx_q         <= idx_d;
            o_frame_valid <= frame_valid_d;
            o_busy        <= busy_d;
            o_len_err     <= len_err_d;
            o_cmd_err     <= cmd_err_d;
            if (drop_inc && o_drop_cnt != 8'hFF) begin
                o_drop_cnt <= o_drop_cnt + 8'd1;
            end
            if (wr_en) begin
                if (idx_q == IDX_W'(0)) o_cmd <= byte_q;
                if (idx_q == IDX_W'(1)) o_page_addr <= byte_q;
                for (int k = 0; k < int'(DATA_BYTES); k++) begin
                    if (idx_q == IDX_W'(k + 2)) o_data[8*k +: 8] <= byte_q;
                end
            end
        end
    end

`ifdef SLIP_CMD_XOR_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_sum_err <= 1'b0;
        end else begin
            o_sum_err <= sum_err_d;
        end
    end
`else
    assign o_sum_err = 1'b0;
    logic unused_sum;
    assign unused_sum = sum_err_d;
`endif

endmodule

// File: tb/tb_slip_cmd_frame_buf.sv
// Scoreboard bench for slip_cmd_frame_buf: stimulus queues expected events,
// a negedge monitor pops and compares on every frame transfer or error pulse.
module tb_slip_cmd_frame_buf;

    localparam int K_FRAME = 0;
    localparam int K_LEN   = 1;
    localparam int K_CMD   = 2;
    localparam int K_SUM   = 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          kind;
        logic [7:0]  cmd;
        logic [7:0]  page;
        logic [63:0] data;
        logic [7:0]  drop;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_rx_started, i_rx_ended, i_rx_byte_done, i_frame_ready;
    logic [7:0]  i_rx_byte;
    logic        o_frame_valid, o_busy, o_len_err, o_cmd_err, o_sum_err;
    logic [7:0]  o_cmd, o_page_addr, o_drop_cnt;
    logic [63:0] o_data;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_drop = 0;

    always #5 clk = ~clk;

    slip_cmd_frame_buf #(.DATA_BYTES(8)) dut (
        .clk(clk), .reset(reset),
        .i_rx_started(i_rx_started), .i_rx_ended(i_rx_ended),
        .i_rx_byte_done(i_rx_byte_done), .i_rx_byte(i_rx_byte),
        .o_frame_valid(o_frame_valid), .i_frame_ready(i_frame_ready),
        .o_cmd(o_cmd), .o_page_addr(o_page_addr), .o_data(o_data),
        .o_busy(o_busy), .o_len_err(o_len_err), .o_cmd_err(o_cmd_err),
        .o_sum_err(o_sum_err), .o_drop_cnt(o_drop_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] c, input logic [7:0] p, input logic [63:0] d);
        exp_t e;
        e.kind = K_FRAME; e.cmd = c; e.page = p; e.data = d; e.drop = 8'h00;
        sb.push_back(e);
    endtask

    task automatic push_err(input int kind);
        exp_t e;
        exp_drop++;
        e.kind = kind; e.cmd = 8'h00; e.page = 8'h00; e.data = 64'h0; e.drop = 8'(exp_drop);
        sb.push_back(e);
    endtask

    task automatic observe(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d want none", kind);
            return;
        end
        e = sb.pop_front();
        check("event_kind", 64'(kind), 64'(e.kind));
        if (e.kind == K_FRAME) begin
            check("frame_cmd", 64'(o_cmd), 64'(e.cmd));
            check("frame_page", 64'(o_page_addr), 64'(e.page));
            check("frame_data", o_data, e.data);
        end else begin
            check("err_drop_cnt", 64'(o_drop_cnt), 64'(e.drop));
        end
    endtask

    // Monitor: every output event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (o_len_err) observe(K_LEN);
            if (o_cmd_err) observe(K_CMD);
            if (o_sum_err) observe(K_SUM);
            if (o_frame_valid && i_frame_ready) observe(K_FRAME);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t mk(input logic [7:0] c, input logic [7:0] p, input logic [63:0] d);
        bq_t q;
        q.push_back(c);
        q.push_back(p);
        for (int k = 0; k < 8; k++) q.push_back(d[8*k +: 8]);
        return q;
    endfunction

    function automatic bq_t with_sum(input bq_t q);
`ifdef SLIP_CMD_XOR_CHECK_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
`endif
        return q;
    endfunction

    task automatic send(input bq_t q, input bit do_start, input bit do_end);
        if (do_start) begin
            i_rx_started = 1'b1; tick(); i_rx_started = 1'b0;
        end
        foreach (q[i]) begin
            i_rx_byte = q[i]; i_rx_byte_done = 1'b1; tick(); i_rx_byte_done = 1'b0;
        end
        if (do_end) begin
            i_rx_ended = 1'b1; tick(); i_rx_ended = 1'b0;
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (!o_frame_valid && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(o_frame_valid), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t f;
        reset = 1'b0;
        i_rx_started = 1'b0; i_rx_ended = 1'b0; i_rx_byte_done = 1'b0;
        i_rx_byte = 8'h00; i_frame_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 64'(o_frame_valid), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_cmd", 64'(o_cmd), 64'd0);
        check("rst_page", 64'(o_page_addr), 64'd0);
        check("rst_data", o_data, 64'd0);
        check("rst_drop", 64'(o_drop_cnt), 64'd0);
        check("rst_errs", 64'({o_len_err, o_cmd_err, o_sum_err}), 64'd0);
        reset = 1'b1;
        repeat (2) tick();

        // Write frame, ready high: valid exactly at N+2 for one cycle.
        i_frame_ready = 1'b1;
        push_frame(8'h01, 8'h05, 64'h8877665544332211);
        send(with_sum(mk(8'h01, 8'h05, 64'h8877665544332211)), 1'b1, 1'b1);
        tick();
        check("t1_valid_n1", 64'(o_frame_valid), 64'd0);
        check("t1_busy_n1", 64'(o_busy), 64'd1);
        tick();
        check("t1_valid_n2", 64'(o_frame_valid), 64'd1);
        tick();
        check("t1_valid_n3", 64'(o_frame_valid), 64'd0);
        check("t1_busy_n3", 64'(o_busy), 64'd0);

        // Read frame held five cycles with ready low.
        i_frame_ready = 1'b0;
        push_frame(8'h00, 8'h3C, 64'h0);
        send(with_sum(mk(8'h00, 8'h3C, 64'h0)), 1'b1, 1'b1);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 64'(o_frame_valid), 64'd1);
            check("t2_hold_cmd", 64'(o_cmd), 64'h00);
            check("t2_hold_page", 64'(o_page_addr), 64'h3C);
            tick();
        end
        i_frame_ready = 1'b1;
        tick();
        check("t2_valid_after", 64'(o_frame_valid), 64'd0);

        // Short and long frames.
        f = with_sum(mk(8'h01, 8'h10, 64'h0102030405060708));
        void'(f.pop_back());
        push_err(K_LEN);
        send(f, 1'b1, 1'b1);
        repeat (4) tick();
        f = with_sum(mk(8'h01, 8'h10, 64'h0102030405060708));
        f.push_back(8'hAA);
        f.push_back(8'hBB);
        push_err(K_LEN);
        send(f, 1'b1, 1'b1);
        repeat (4) tick();
        check("t3_drop", 64'(o_drop_cnt), 64'd2);

        // Unknown opcode.
        push_err(K_CMD);
        send(with_sum(mk(8'h07, 8'h01, 64'h1111111111111111)), 1'b1, 1'b1);
        repeat (4) tick();
        check("t4_valid", 64'(o_frame_valid), 64'd0);

        // Start during HOLD: whole colliding frame dropped, held frame intact.
        i_frame_ready = 1'b0;
        push_frame(8'h01, 8'h22, 64'hA1A2A3A4A5A6A7A8);
        send(with_sum(mk(8'h01, 8'h22, 64'hA1A2A3A4A5A6A7A8)), 1'b1, 1'b1);
        wait_valid("t5_wait_valid", 10);
        exp_drop++;
        send(with_sum(mk(8'h00, 8'h99, 64'hFFFFFFFFFFFFFFFF)), 1'b1, 1'b1);
        check("t5_drop", 64'(o_drop_cnt), 64'(exp_drop));
        check("t5_hold_page", 64'(o_page_addr), 64'h22);
        i_frame_ready = 1'b1;
        repeat (2) tick();
        check("t5_valid_after", 64'(o_frame_valid), 64'd0);
        push_frame(8'h00, 8'h44, 64'h0F0E0D0C0B0A0908);
        send(with_sum(mk(8'h00, 8'h44, 64'h0F0E0D0C0B0A0908)), 1'b1, 1'b1);
        repeat (4) tick();

        // Restart inside COLLECT, then a clean frame.
        f = mk(8'h01, 8'h02, 64'h0);
        f = f[0:2];
        push_err(K_LEN);
        push_frame(8'h01, 8'h77, 64'h1234567890ABCDEF);
        send(f, 1'b1, 1'b0);
        send(with_sum(mk(8'h01, 8'h77, 64'h1234567890ABCDEF)), 1'b1, 1'b1);
        repeat (4) tick();

`ifdef SLIP_CMD_XOR_CHECK_EN
        // Checksum good (09) and bad (00).
        push_frame(8'h01, 8'h00, 64'h0807060504030201);
        f = mk(8'h01, 8'h00, 64'h0807060504030201);
        f.push_back(8'h09);
        send(f, 1'b1, 1'b1);
        repeat (4) tick();
        push_err(K_SUM);
        f = mk(8'h01, 8'h00, 64'h0807060504030201);
        f.push_back(8'h00);
        send(f, 1'b1, 1'b1);
        repeat (4) tick();
`endif

        // Reset mid-frame after four bytes.
        f = mk(8'h01, 8'h03, 64'h5555555555555555);
        f = f[0:3];
        send(f, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        exp_drop = 0;
        check("t8_valid", 64'(o_frame_valid), 64'd0);
        check("t8_busy", 64'(o_busy), 64'd0);
        check("t8_drop", 64'(o_drop_cnt), 64'd0);
        check("t8_cmd", 64'(o_cmd), 64'd0);
        check("t8_data", o_data, 64'd0);
        reset = 1'b1;
        tick();
        push_frame(8'h01, 8'h5A, 64'hCAFEF00DDEADBEEF);
        send(with_sum(mk(8'h01, 8'h5A, 64'hCAFEF00DDEADBEEF)), 1'b1, 1'b1);
        repeat (5) tick();
        check("t8_drop_after", 64'(o_drop_cnt), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
